// File: rtl/music_pkg.sv
// Shared types and field widths for the note sequencer and its note-ROM bus.
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 6;
    localparam int ADDR_W = 2 + IDX_W;
    localparam int WORD_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] NOTE_REST      = '0;
    localparam logic [DUR_W-1:0]  END_MARKER_DUR = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_word_t;

endpackage

// File: rtl/music_sequencer_if.sv
// Note-ROM bus: the sequencer drives the address, the ROM returns the word one clock later.
interface music_sequencer_if;
    import music_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);

endinterface

// File: rtl/music_sequencer_tick_down_counter.sv
// Loadable down-counter; done flags the enabled step that leaves count 1.
module tick_down_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    // NOTE: count_d gets a default before any branch so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = en && (count_q == W'(1));

endmodule

// File: rtl/music_sequencer.sv
// Walks the selected song in note ROM, plays each note for its duration in ticks,
// and pulses force_prox at end of song so the selector moves to the next track.
module music_sequencer
    import music_pkg::*;
#(
    parameter int GAP_TICKS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         select,
    input  logic               start,
    input  logic               tick,
    input  logic               pause,
    music_sequencer_if.master  mem,
    output logic [NOTE_W-1:0]  note,
    output logic               playing,
    output logic               force_prox
);

    localparam logic [DUR_W-1:0] GAP_VAL = DUR_W'(GAP_TICKS);

    state_e            state_q, state_d;
    logic [1:0]        song_q, song_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              playing_q, playing_d;
    logic              force_prox_q, force_prox_d;
    logic              advance;

    rom_word_t word;
    logic      run_en;
    logic      dur_done, gap_done;

    assign word   = rom_word_t'(mem.mem_data);
    assign run_en = tick && !pause && !start;

    tick_down_counter #(.W(DUR_W)) u_dur_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == S_LOAD && word.dur != END_MARKER_DUR && !start),
        .load_val (word.dur),
        .en       (state_q == S_PLAY && run_en),
        .done     (dur_done)
    );

    tick_down_counter #(.W(DUR_W)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (dur_done),
        .load_val (GAP_VAL),
        .en       (state_q == S_GAP && run_en),
        .done     (gap_done)
    );

    always_comb begin
        state_d      = state_q;
        song_d       = song_q;
        index_d      = index_q;
        note_d       = note_q;
        force_prox_d = 1'b0;
        advance      = 1'b0;

        if (start) begin
            song_d  = select;
            index_d = '0;
            note_d  = NOTE_REST;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE:  note_d = NOTE_REST;
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (word.dur == END_MARKER_DUR) begin
                        note_d  = NOTE_REST;
                        state_d = S_DONE;
                    end else begin
                        note_d  = word.note;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (dur_done) begin
                        if (GAP_TICKS > 0) begin
                            note_d  = NOTE_REST;
                            state_d = S_GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    note_d  = NOTE_REST;
                    advance = gap_done;
                end
                S_DONE: begin
                    note_d       = NOTE_REST;
                    force_prox_d = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // The last index of a song ends it rather than spilling into the next song.
            if (advance) begin
                if (&index_q) begin
                    note_d  = NOTE_REST;
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
        end

        playing_d = (state_d == S_PLAY) || (state_d == S_GAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            song_q       <= '0;
            index_q      <= '0;
            note_q       <= NOTE_REST;
            playing_q    <= 1'b0;
            force_prox_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            index_q      <= index_d;
            note_q       <= note_d;
            playing_q    <= playing_d;
            force_prox_q <= force_prox_d;
        end
    end

    assign mem.mem_addr = {song_q, index_q};
    assign note         = note_q;
    assign playing      = playing_q;
    assign force_prox   = force_prox_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench: one sequencer with a one-tick gap and one legato sequencer share stimulus.
module tb_music_sequencer;
    import music_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        select;
    logic              start, tick, pause;
    logic [NOTE_W-1:0] note, note0;
    logic              playing, playing0, force_prox, force_prox0;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0] rom [0:255];

    music_sequencer_if mem_if ();
    music_sequencer_if mem_if0 ();

    always #5 clk = ~clk;

    always @(posedge clk) mem_if.mem_data  <= rom[mem_if.mem_addr];
    always @(posedge clk) mem_if0.mem_data <= rom[mem_if0.mem_addr];

    music_sequencer #(.GAP_TICKS(1)) u_dut (
        .clk(clk), .reset(reset), .select(select), .start(start), .tick(tick),
        .pause(pause), .mem(mem_if.master), .note(note), .playing(playing),
        .force_prox(force_prox)
    );

    music_sequencer #(.GAP_TICKS(0)) u_dut0 (
        .clk(clk), .reset(reset), .select(select), .start(start), .tick(tick),
        .pause(pause), .mem(mem_if0.master), .note(note0), .playing(playing0),
        .force_prox(force_prox0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        select = sel;
        start  = 1'b1;
        cyc(1'b0);
        start  = 1'b0;
    endtask

    typedef struct {
        logic [1:0]        sel;
        logic [7:0]        exp_addr;
        logic [NOTE_W-1:0] exp_note;
    } latency_vec_t;

    latency_vec_t      lat_tbl [4];
    logic [NOTE_W-1:0] song2_exp [7];
    logic [NOTE_W-1:0] seen_q [$];

    initial begin
        int  cnt;
        int  words;
        int  bad_song;
        int  max_addr;
        bit  seen;

        lat_tbl[0] = '{2'd0, 8'h00, 6'd3};
        lat_tbl[1] = '{2'd1, 8'h40, 6'd9};
        lat_tbl[2] = '{2'd2, 8'h80, 6'd5};
        lat_tbl[3] = '{2'd3, 8'hC0, 6'd11};
        song2_exp  = '{6'd5, 6'd5, 6'd5, 6'd0, 6'd7, 6'd7, 6'd0};

        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[8'h00] = {6'd3, 6'd2};
        rom[8'h40] = {6'd9, 6'd4};
        rom[8'h80] = {6'd5, 6'd3};
        rom[8'h81] = {6'd7, 6'd2};
        rom[8'h82] = {6'd9, 6'd0};
        for (int i = 8'hC0; i < 256; i++) rom[i] = {6'd11, 6'd1};

        reset = 1'b1; select = '0; start = 1'b0; tick = 1'b0; pause = 1'b0;
        cyc(1'b0);
        cyc(1'b1);
        check("reset_note", note, 0);
        check("reset_playing", playing, 0);
        check("reset_force", force_prox, 0);
        check("reset_addr", mem_if.mem_addr, 0);
        #2 reset = 1'b0;
        cyc(1'b0);

        // Start-to-note latency for every song slot.
        for (int i = 0; i < 4; i++) begin
            pulse_start(lat_tbl[i].sel);
            check($sformatf("lat%0d_fetch_addr", i), mem_if.mem_addr, lat_tbl[i].exp_addr);
            cyc(1'b0);
            check($sformatf("lat%0d_load_playing", i), playing, 0);
            cyc(1'b0);
            check($sformatf("lat%0d_note", i), note, lat_tbl[i].exp_note);
        end

        // Full playback of song 2 with a tick every fourth clock.
        pulse_start(2'd2);
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            logic t;
            t = (c % 4 == 3);
            if (t && playing) seen_q.push_back(note);
            cyc(t);
            if (force_prox) seen = 1;
        end
        check("song2_end_seen", seen, 1);
        check("song2_tick_count", seen_q.size(), 7);
        for (int i = 0; i < 7 && i < seen_q.size(); i++)
            check($sformatf("song2_tick%0d_note", i), seen_q[i], song2_exp[i]);
        check("song2_end_note", note, 0);
        check("song2_end_playing", playing, 0);
        cyc(1'b0);
        check("song2_force_width", force_prox, 0);

        // Restart into song 1 while song 2's first note is sounding.
        pulse_start(2'd2);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        check("midnote_before_restart", note, 5);
        pulse_start(2'd1);
        check("restart_note_rest", note, 0);
        check("restart_addr", mem_if.mem_addr, 8'h40);
        check("restart_force", force_prox, 0);
        cyc(1'b0);
        check("restart_force_load", force_prox, 0);
        cyc(1'b0);
        check("restart_note", note, 9);

        // Pause for 10 ticks after one tick of a four-tick note.
        cyc(1'b1);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        check("pause_note_held", note, 9);
        check("pause_playing", playing, 1);
        pause = 1'b0;
        cnt = 0;
        while (note == 9 && cnt < 8) begin
            cyc(1'b1);
            cnt++;
        end
        check("pause_remaining_ticks", cnt, 3);
        check("pause_into_gap", playing, 1);

        // Gap tick, then FETCH, LOAD of the marker, then DONE; start lands in DONE.
        cyc(1'b1);
        check("gap_end_playing", playing, 0);
        cyc(1'b0);
        cyc(1'b0);
        pulse_start(2'd2);
        check("done_start_force", force_prox, 0);
        check("done_start_addr", mem_if.mem_addr, 8'h80);
        cyc(1'b0);
        check("done_start_force_next", force_prox, 0);
        cyc(1'b0);
        check("done_start_note", note, 5);

        // Legato song with no end marker: all 64 words then force_prox.
        pulse_start(2'd3);
        seen = 0; words = 0; bad_song = 0; max_addr = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            logic t;
            t = (c % 4 == 3);
            if (t && playing0) words++;
            if (mem_if0.mem_addr[7:6] != 2'd3) bad_song++;
            if (int'(mem_if0.mem_addr) > max_addr) max_addr = int'(mem_if0.mem_addr);
            cyc(t);
            if (force_prox0) seen = 1;
        end
        check("nomark_end_seen", seen, 1);
        check("nomark_words", words, 64);
        check("nomark_addr_in_song", bad_song, 0);
        check("nomark_max_addr", max_addr, 8'hFF);
        cyc(1'b0);
        check("nomark_force_width", force_prox0, 0);

        // Asynchronous reset in the middle of a note.
        pulse_start(2'd2);
        cyc(1'b0);
        cyc(1'b0);
        check("prereset_note", note, 5);
        #2 reset = 1'b1;
        #1;
        check("async_reset_note", note, 0);
        check("async_reset_playing", playing, 0);
        check("async_reset_force", force_prox, 0);
        check("async_reset_addr", mem_if.mem_addr, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1);
        check("after_reset_note", note, 0);
        check("after_reset_playing", playing, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
